// File: rtl/step_tracker_bcd.sv
// Pedometer core clocked by the debounced step pulse: saturating BCD step total,
// half-mile distance, clearable lap count, and a mode-selected 5-bit-per-digit display bus.
module step_tracker_bcd #(
    parameter int NUM_DIGITS          = 4,
    parameter int STEPS_PER_HALF_MILE = 1024
) (
    input  logic                    step_clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    lap_clr,
    output logic [5*NUM_DIGITS-1:0] bcd,
    output logic                    si,
    output logic                    dist_sat
);

    localparam int            PW      = $clog2(STEPS_PER_HALF_MILE);
    localparam int            MD      = NUM_DIGITS - 2;
    localparam logic [PW-1:0] PS_LAST = PW'(STEPS_PER_HALF_MILE - 1);
    localparam logic [4:0]    BLANK   = 5'h1F;

    logic [NUM_DIGITS-1:0][3:0] total_q, total_inc;
    logic [NUM_DIGITS-1:0][3:0] lap_q, lap_inc;
    logic [MD-1:0][3:0]         miles_q, miles_inc;
    logic                       total_full, lap_full, miles_full;
    logic                       half_q;
    logic [PW-1:0]              ps_q;
    logic                       tick;

    // Returns {all_nines, value+1}; the carry out of the top digit is set only when every digit was 9.
    function automatic logic [4*NUM_DIGITS:0] bcd_inc(input logic [NUM_DIGITS-1:0][3:0] v);
        logic [NUM_DIGITS-1:0][3:0] r;
        logic                       c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (c) begin
                if (v[d] == 4'd9) begin
                    r[d] = 4'd0;
                end else begin
                    r[d] = v[d] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        {total_full, total_inc} = bcd_inc(total_q);
        {lap_full, lap_inc}     = bcd_inc(lap_q);
    end

    always_comb begin
        logic c;
        miles_inc = miles_q;
        c         = 1'b1;
        for (int d = 0; d < MD; d++) begin
            if (c) begin
                if (miles_q[d] == 4'd9) begin
                    miles_inc[d] = 4'd0;
                end else begin
                    miles_inc[d] = miles_q[d] + 4'd1;
                    c            = 1'b0;
                end
            end
        end
        miles_full = c;
    end

    assign tick = (ps_q == PS_LAST);

    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            total_q  <= '0;
            lap_q    <= '0;
            miles_q  <= '0;
            half_q   <= 1'b0;
            ps_q     <= '0;
            si       <= 1'b0;
            dist_sat <= 1'b0;
        end else begin
            if (total_full) begin
                si <= 1'b1;
            end else begin
                total_q <= total_inc;
            end

            if (lap_clr) begin
                lap_q <= '0;
            end else if (!lap_full) begin
                lap_q <= lap_inc;
            end

            ps_q <= tick ? '0 : ps_q + PW'(1);

            // Distance freezes at its maximum; the prescaler keeps wrapping regardless.
            if (tick) begin
                if (!half_q) begin
                    half_q <= 1'b1;
                end else if (miles_full) begin
                    dist_sat <= 1'b1;
                end else begin
                    half_q  <= 1'b0;
                    miles_q <= miles_inc;
                end
            end
        end
    end

    always_comb begin
        bcd = '0;
        case (mode)
            2'd0: begin
                for (int d = 0; d < NUM_DIGITS; d++) bcd[5*d +: 5] = {1'b0, total_q[d]};
            end
            2'd1: begin
                bcd[4:0] = half_q ? 5'd5 : 5'd0;
                bcd[9:5] = BLANK;
                for (int d = 2; d < NUM_DIGITS; d++) bcd[5*d +: 5] = {1'b0, miles_q[d-2]};
            end
            2'd2: begin
                for (int d = 0; d < NUM_DIGITS; d++) bcd[5*d +: 5] = {1'b0, lap_q[d]};
            end
            default: begin
                for (int d = 0; d < NUM_DIGITS; d++) bcd[5*d +: 5] = BLANK;
            end
        endcase
    end

endmodule
